// File: rtl/seq_detector_param.sv
// Programmable Moore serial pattern detector with a valid qualifier and a
// saturating match counter. The pattern, its length and the overlap mode are
// loaded at runtime through a config write port.
module seq_detector_param #(
    parameter int                 MAX_LEN     = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0001_0110,
    parameter int                 DEF_LEN     = 5,
    parameter bit                 DEF_OVERLAP = 1'b1,
    parameter int                 CNT_W       = 8,
    localparam int                LW          = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_overlap,
    output logic               cfg_err,
    input  logic               in_valid,
    input  logic               j,
    input  logic               cnt_clr,
    output logic               w,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat
);

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] pattern_q;
    logic [MAX_LEN-1:0] len_mask;
    logic [LW-1:0]      fill_q, fill_inc;
    logic [LW-1:0]      len_q;
    logic               overlap_q;
    logic               w_q;
    logic               cfg_err_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sample;
    logic               match;
    logic               cfg_legal;

    always_comb begin
        sample    = in_valid && !cfg_we;
        hist_d    = {hist_q[MAX_LEN-2:0], j};
        fill_inc  = (fill_q >= LW'(MAX_LEN)) ? LW'(MAX_LEN) : fill_q + LW'(1);
        cfg_legal = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));
        // Only the low len bits take part in the compare; the rest are don't-care.
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LW'(i) < len_q);
        end
        match = (fill_inc >= len_q) && (((hist_d ^ pattern_q) & len_mask) == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pattern_q <= DEF_PATTERN;
            len_q     <= LW'(DEF_LEN);
            overlap_q <= DEF_OVERLAP;
            w_q       <= 1'b0;
            cfg_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here sees the pre-edge values.
            cfg_err_q <= cfg_we && !cfg_legal;

            if (cfg_we) begin
                if (cfg_legal) begin
                    pattern_q <= cfg_pattern;
                    len_q     <= cfg_len;
                    overlap_q <= cfg_overlap;
                    hist_q    <= '0;
                    fill_q    <= '0;
                    w_q       <= 1'b0;
                end
            end else if (in_valid) begin
                hist_q <= hist_d;
                fill_q <= (match && !overlap_q) ? '0 : fill_inc;
                w_q    <= match;
            end

            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (sample && match && !cnt_sat) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign w         = w_q;
    assign cfg_err   = cfg_err_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = &cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: a default instance and a 2-bit
// counter instance share one stimulus stream; expected w values queue up per step.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LW      = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic               cfg_overlap;
    logic               in_valid;
    logic               j;
    logic               cnt_clr;

    logic       cfg_err, w, cnt_sat;
    logic [7:0] match_cnt;
    logic       cfg_err2, w2, cnt_sat2;
    logic [1:0] match_cnt2;

    typedef struct {
        logic  w;
        string tag;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    seq_detector_param dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err),
        .in_valid(in_valid), .j(j), .cnt_clr(cnt_clr), .w(w),
        .match_cnt(match_cnt), .cnt_sat(cnt_sat)
    );

    seq_detector_param #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err2),
        .in_valid(in_valid), .j(j), .cnt_clr(cnt_clr), .w(w2),
        .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic bit_step(input logic v, input logic b, input logic ew,
                            input logic clr, input string tag);
        exp_t e;
        in_valid = v;
        j        = b;
        cnt_clr  = clr;
        e.w      = ew;
        e.tag    = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        j        = 1'b0;
        cnt_clr  = 1'b0;
        e = sb_q.pop_front();
        check(e.tag, {31'd0, w}, {31'd0, e.w});
    endtask

    task automatic run(input string bits, input string ws, input bit gap, input string tag);
        for (int i = 0; i < bits.len(); i++) begin
            bit_step(1'b1, bits[i] == "1", ws[i] == "1", 1'b0, $sformatf("%s[%0d]", tag, i));
            if (gap) begin
                bit_step(1'b0, 1'b1, ws[i] == "1", 1'b0, $sformatf("%s_idle[%0d]", tag, i));
            end
        end
    endtask

    task automatic cfg_write(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                             input logic v, input logic b, input logic exp_err,
                             input string tag);
        cfg_we      = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        in_valid    = v;
        j           = b;
        @(posedge clk);
        #1;
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        j        = 1'b0;
        check({tag, "_err"}, {31'd0, cfg_err}, {31'd0, exp_err});
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        in_valid = 1'b0; j = 1'b0; cnt_clr = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_w",       {31'd0, w},       0);
        check("rst_cnt",     {24'd0, match_cnt}, 0);
        check("rst_sat",     {31'd0, cnt_sat}, 0);
        check("rst_cfg_err", {31'd0, cfg_err}, 0);
        check("rst_cnt2",    {30'd0, match_cnt2}, 0);
        rst = 1'b0;

        // Default 10110, overlapping.
        run("10110110", "00001001", 1'b0, "ovl");
        check("ovl_cnt",  {24'd0, match_cnt}, 2);
        check("ovl_cnt2", {30'd0, match_cnt2}, 2);

        // Non-overlapping.
        cfg_write(8'h16, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, "cfg_nov");
        check("cfg_nov_w",   {31'd0, w}, 0);
        check("cfg_nov_cnt", {24'd0, match_cnt}, 2);
        run("10110110", "00001000", 1'b0, "nov");
        check("nov_cnt", {24'd0, match_cnt}, 3);

        // Valid gating with idle cycles carrying j=1.
        cfg_write(8'h16, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, "cfg_gap");
        run("10110110", "00001001", 1'b1, "gap");
        check("gap_cnt", {24'd0, match_cnt}, 5);

        // Illegal config writes drop the coincident bit and keep the config.
        cfg_write(8'h16, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, "cfg_drop");
        run("1011", "0000", 1'b0, "drop_pre");
        cfg_write(8'hFF, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, "ill_len0");
        check("ill_len0_w", {31'd0, w}, 0);
        cfg_write(8'hFF, 4'd9, 1'b0, 1'b1, 1'b0, 1'b1, "ill_len9");
        run("0", "1", 1'b0, "drop_post");
        check("ill_err_clear", {31'd0, cfg_err}, 0);
        run("110", "001", 1'b0, "ovl_kept");
        check("ill_cnt", {24'd0, match_cnt}, 7);

        // Full-width pattern.
        cfg_write(8'hA5, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, "cfg_len8");
        run("1010010110100101", "0000000100000001", 1'b0, "len8");
        check("len8_cnt", {24'd0, match_cnt}, 9);

        // Single-bit pattern; upper pattern bits must be ignored.
        cfg_write(8'hF1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, "cfg_len1");
        run("1101001", "1101001", 1'b0, "len1");
        cfg_write(8'hF1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, "cfg_len1_nov");
        run("0110", "0110", 1'b0, "len1_nov");
        check("len1_cnt", {24'd0, match_cnt}, 15);

        // Saturating counter on the 2-bit instance.
        cfg_write(8'h16, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, "cfg_cnt");
        bit_step(1'b0, 1'b0, 1'b0, 1'b1, "clr");
        check("clr_cnt",  {24'd0, match_cnt}, 0);
        check("clr_cnt2", {30'd0, match_cnt2}, 0);
        run("10110", "00001", 1'b0, "m1");
        check("m1_cnt2", {30'd0, match_cnt2}, 1);
        check("m1_sat2", {31'd0, cnt_sat2}, 0);
        run("110", "001", 1'b0, "m2");
        check("m2_cnt2", {30'd0, match_cnt2}, 2);
        check("m2_sat2", {31'd0, cnt_sat2}, 0);
        run("110", "001", 1'b0, "m3");
        check("m3_cnt2", {30'd0, match_cnt2}, 3);
        check("m3_sat2", {31'd0, cnt_sat2}, 1);
        run("110", "001", 1'b0, "m4");
        check("m4_cnt2", {30'd0, match_cnt2}, 3);
        run("110", "001", 1'b0, "m5");
        check("m5_cnt2", {30'd0, match_cnt2}, 3);
        check("m5_sat2", {31'd0, cnt_sat2}, 1);
        check("m5_cnt",  {24'd0, match_cnt}, 5);
        check("m5_sat",  {31'd0, cnt_sat}, 0);

        // Clear coincident with a match: w still rises, count not taken.
        run("11", "00", 1'b0, "clr_pre");
        bit_step(1'b1, 1'b0, 1'b1, 1'b1, "clr_match");
        check("clr_match_cnt",  {24'd0, match_cnt}, 0);
        check("clr_match_cnt2", {30'd0, match_cnt2}, 0);

        // Async reset mid-pattern discards progress.
        run("110", "001", 1'b0, "pre_rst");
        check("pre_rst_cnt", {24'd0, match_cnt}, 1);
        run("101", "000", 1'b0, "part");
        #2 rst = 1'b1;
        #1;
        check("arst_cnt", {24'd0, match_cnt}, 0);
        check("arst_w",   {31'd0, w}, 0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        run("10", "00", 1'b0, "post_rst");
        check("post_rst_cnt", {24'd0, match_cnt}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
